item_mem_ctrl: RTL
==================

Name: item_mem_ctrl

Overview:
- Owns the single-port item SRAM and shares it between three requesters: vending FSM lookup reads, vending FSM stock-decrement updates, and the configuration host (price and stock load, readback).
- Sits between the vending main FSM and the SRAM macro.
- Converts the FSM's fire-and-forget pulses into sequenced SRAM accesses, including the read-modify-write needed for the stock decrement.

Parameters:
- ADDR_W, 10, item address width; depth = 2**ADDR_W.
- COST_W, 16, item cost width.
- AVAIL_W, 8, stock count width.
- DATA_W, COST_W+AVAIL_W, SRAM word width, packed as {avail, cost}.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- fsm_rd_en  in  1  one-cycle lookup request pulse
- fsm_rd_addr  in  ADDR_W  lookup item
- fsm_item_cost  out  COST_W  lookup result
- fsm_item_available  out  AVAIL_W  lookup result
- fsm_data_valid  out  1  one-cycle result pulse
- fsm_upd_en  in  1  one-cycle stock-decrement pulse
- fsm_upd_addr  in  ADDR_W  item to decrement
- cfg_valid  in  1  host request valid
- cfg_ready  out  1  host request accepted this cycle
- cfg_we  in  1  1 = write, 0 = read
- cfg_addr  in  ADDR_W  host item address
- cfg_wdata  in  DATA_W  host write word
- cfg_rdata  out  DATA_W  host read word
- cfg_rvalid  out  1  one-cycle host read-data pulse
- sram_ce  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access
- err_overrun  out  1  sticky: a pending FSM request was overwritten
- sales_count  out  32  successful decrement count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, pending flags clear. Reset is asynchronous, so sram_ce drops immediately mid-operation and any in-flight RMW is abandoned.
- Request capture: fsm_rd_en and fsm_upd_en set one-entry pending registers (flag + addr) at the clock edge.
  - A new pulse that arrives while the same-kind pending flag is still set overwrites the stored address and sets err_overrun.
  - A pulse in the cycle its pending entry is being granted is captured as a fresh entry, not an overrun.
- Arbitration runs only in IDLE, with fixed priority: pending update > pending read > cfg_valid.
  - cfg_ready is high only in IDLE when no FSM request is pending.
- State machine:
  - IDLE: grant per priority. Update -> UPD_RD; read -> RD; cfg write -> CFG_WR; cfg read -> CFG_RD. In the grant cycle, drive sram_ce=1, sram_we=0, sram_addr=granted address.
  - RD: sram_rdata is valid. Register it into fsm_item_cost/fsm_item_available and pulse fsm_data_valid the next cycle. Next state IDLE.
  - UPD_RD: sram_rdata is valid.
    - If avail != 0: next UPD_WR, with the word latched and avail decremented by 1.
    - If avail == 0: next IDLE with no write (saturating, no underflow).
  - UPD_WR: sram_ce=1, sram_we=1, same address, word {avail-1, cost}; sales_count increments. Next IDLE.
  - CFG_WR: entered from IDLE, which drives sram_ce=1, sram_we=1 directly in the grant cycle. CFG_WR itself is a one-cycle turnaround. Next IDLE.
  - CFG_RD: sram_rdata is valid. Register it to cfg_rdata and pulse cfg_rvalid the next cycle. Next IDLE.
- Latency, uncontended, with the request pulse sampled at edge T:
  - Lookup: grant cycle T+1, fsm_data_valid high during cycle T+3.
  - Decrement: SRAM write during cycle T+3.
  - cfg read (handshake at edge T): cfg_rvalid high during cycle T+2.
- Ordering:
  - An update and a read for the same item pending together: the update completes first, so the read returns the post-decrement stock.
  - The cfg port may starve while FSM traffic is continuous; this is accepted.
- Result registers (fsm_item_*, cfg_rdata) hold their value until the next result.
- Exactly one SRAM access per granted transaction phase; never ce in RD, CFG_RD, or CFG_WR.

Optional Feature:
- ITEM_SALES_CNT_EN defined: sales_count is a 32-bit register, reset 0, incremented on each UPD_WR, wrapping at 2^32-1 to 0.
- Not defined: no counter logic; sales_count is tied to 0.

Decomposition:
- Shared package vend_pkg holds:
  - ADDR_W/COST_W/AVAIL_W defaults.
  - the item word typedef struct {avail, cost}.
  - the arbiter state enum (IDLE, RD, UPD_RD, UPD_WR, CFG_RD, CFG_WR).
- One natural sub-module: item_req_latch, the pending flag/address/overrun capture, instantiated twice (read, update).

Test Plan:
- Lookup: cfg write addr 5 = {avail 3, cost 150}, then fsm_rd_en addr 5 -> fsm_data_valid during T+3 with cost 150, available 3.
- Decrement: fsm_upd_en addr 5 (avail 3) -> SRAM write {2,150}; a subsequent lookup returns available 2; sales_count = 1 with ITEM_SALES_CNT_EN.
- Saturation: decrement addr 7 holding avail 0 -> no sram_we pulse, avail stays 0, sales_count unchanged.
- Contention: fsm_upd_en and fsm_rd_en addr 5 in the same cycle while cfg_valid is high -> order UPD_RD, UPD_WR, RD, then cfg; lookup returns decremented stock; cfg_ready low until both FSM requests are done.
- Overrun: two fsm_rd_en pulses while the block is busy in a cfg RMW/update sequence -> err_overrun=1; only the second address is read.
- Reset mid-RMW: deassert rstn during UPD_RD -> sram_ce=0 immediately, all outputs 0, no write issued, state IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default widths for the vending item memory path.
package vend_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int COST_W_DEF  = 16;
  localparam int AVAIL_W_DEF = 8;

  // One SRAM word: stock count in the upper bits, cost in the lower bits.
  typedef struct packed {
    logic [AVAIL_W_DEF-1:0] avail;
    logic [COST_W_DEF-1:0]  cost;
  } item_word_t;

  // Arbiter / sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    UPD_RD = 3'd2,
    UPD_WR = 3'd3,
    CFG_RD = 3'd4,
    CFG_WR = 3'd5
  } arb_state_e;

endpackage

// File: rtl/item_req_latch.sv
// One-entry pending request holder (flag + address) with sticky overrun.
// A request arriving while an older one is still waiting replaces it and
// raises the overrun flag; a request arriving in the grant cycle is simply
// a fresh entry.
module item_req_latch #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_grant,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_overrun
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overrun;

  // Capture new requests, clear on grant, flag overwrites of waiting entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
    end else if (i_req) begin
      r_pend <= 1'b1;
      r_addr <= i_addr;
      if (r_pend && !i_grant) r_overrun <= 1'b1;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend    = r_pend;
  assign o_addr    = r_addr;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/item_mem_ctrl.sv
// Item SRAM owner: arbitrates FSM lookups, FSM stock decrements (RMW) and
// host config accesses onto a single-port SRAM.
// Optional build macro: ITEM_SALES_CNT_EN enables the 32-bit sales counter;
// without it sales_count is tied to zero.
//
// Host handshake: a cfg request transfers on a rising edge where both
// cfg_valid and cfg_ready are high; cfg_valid with cfg_ready low is held by
// the host, and cfg_ready never depends combinationally on cfg_valid.
module item_mem_ctrl
  import vend_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COST_W  = COST_W_DEF,
  parameter int AVAIL_W = AVAIL_W_DEF,
  parameter int DATA_W  = COST_W + AVAIL_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fsm_rd_en,
  input  logic [ADDR_W-1:0]  fsm_rd_addr,
  output logic [COST_W-1:0]  fsm_item_cost,
  output logic [AVAIL_W-1:0] fsm_item_available,
  output logic               fsm_data_valid,
  input  logic               fsm_upd_en,
  input  logic [ADDR_W-1:0]  fsm_upd_addr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  cfg_rdata,
  output logic               cfg_rvalid,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               err_overrun,
  output logic [31:0]        sales_count,
  output logic [2:0]         dbg_state
);

  arb_state_e        r_state;
  logic              r_active;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_word;

  logic              w_rd_pend, w_upd_pend, w_rd_ovr, w_upd_ovr;
  logic [ADDR_W-1:0] w_rd_addr, w_upd_addr;
  logic              w_idle, w_grant_upd, w_grant_rd, w_cfg_fire;
  logic [AVAIL_W-1:0] w_rd_avail, w_dec_avail;
  logic [COST_W-1:0]  w_rd_cost;

  item_req_latch #(.ADDR_W(ADDR_W)) u_rd_latch (
    .clk(clk), .rstn(rstn), .i_req(fsm_rd_en), .i_addr(fsm_rd_addr),
    .i_grant(w_grant_rd), .o_pend(w_rd_pend), .o_addr(w_rd_addr),
    .o_overrun(w_rd_ovr)
  );

  item_req_latch #(.ADDR_W(ADDR_W)) u_upd_latch (
    .clk(clk), .rstn(rstn), .i_req(fsm_upd_en), .i_addr(fsm_upd_addr),
    .i_grant(w_grant_upd), .o_pend(w_upd_pend), .o_addr(w_upd_addr),
    .o_overrun(w_upd_ovr)
  );

  // r_active keeps every grant (and cfg_ready) off until the first edge
  // after reset release, so nothing reaches the SRAM while rstn is low.
  assign w_idle      = r_active && (r_state == IDLE);
  assign w_grant_upd = w_idle && w_upd_pend;
  assign w_grant_rd  = w_idle && !w_upd_pend && w_rd_pend;
  assign cfg_ready   = w_idle && !w_upd_pend && !w_rd_pend;
  assign w_cfg_fire  = cfg_ready && cfg_valid;
  assign err_overrun = w_rd_ovr | w_upd_ovr;
  assign dbg_state   = r_state;

  assign w_rd_avail  = sram_rdata[DATA_W-1:COST_W];
  assign w_rd_cost   = sram_rdata[COST_W-1:0];
  assign w_dec_avail = w_rd_avail - {{(AVAIL_W-1){1'b0}}, 1'b1};

  // Arm the arbiter one edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_active <= 1'b0;
    else       r_active <= 1'b1;
  end

  // Sequencer: grant in IDLE, collect read data, build the decrement word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state            <= IDLE;
      r_addr             <= '0;
      r_word             <= '0;
      fsm_item_cost      <= '0;
      fsm_item_available <= '0;
      fsm_data_valid     <= 1'b0;
      cfg_rdata          <= '0;
      cfg_rvalid         <= 1'b0;
    end else begin
      fsm_data_valid <= 1'b0;
      cfg_rvalid     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_upd) begin
            r_addr  <= w_upd_addr;
            r_state <= UPD_RD;
          end else if (w_grant_rd) begin
            r_state <= RD;
          end else if (w_cfg_fire) begin
            r_state <= cfg_we ? CFG_WR : CFG_RD;
          end
        end
        RD: begin
          fsm_item_cost      <= w_rd_cost;
          fsm_item_available <= w_rd_avail;
          fsm_data_valid     <= 1'b1;
          r_state            <= IDLE;
        end
        UPD_RD: begin
          // Empty stock saturates: no write-back at all.
          if (w_rd_avail != '0) begin
            r_word  <= {w_dec_avail, w_rd_cost};
            r_state <= UPD_WR;
          end else begin
            r_state <= IDLE;
          end
        end
        UPD_WR:  r_state <= IDLE;
        CFG_RD: begin
          cfg_rdata  <= sram_rdata;
          cfg_rvalid <= 1'b1;
          r_state    <= IDLE;
        end
        CFG_WR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // SRAM command: issued in the grant cycle, or the RMW write-back cycle.
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_upd) begin
          sram_ce   = 1'b1;
          sram_addr = w_upd_addr;
        end else if (w_grant_rd) begin
          sram_ce   = 1'b1;
          sram_addr = w_rd_addr;
        end else if (w_cfg_fire) begin
          sram_ce    = 1'b1;
          sram_we    = cfg_we;
          sram_addr  = cfg_addr;
          sram_wdata = cfg_we ? cfg_wdata : '0;
        end
      end
      UPD_WR: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = r_addr;
        sram_wdata = r_word;
      end
      default: ;
    endcase
  end

`ifdef ITEM_SALES_CNT_EN
  logic [31:0] r_sales;

  // Count every completed decrement write-back; wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 r_sales <= '0;
    else if (r_state == UPD_WR) r_sales <= r_sales + 32'd1;
  end

  assign sales_count = r_sales;
`else
  assign sales_count = '0;
`endif

endmodule
